// File: rtl/multicycle_control_fsm.sv
// Multicycle datapath controller: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and mux selects, and decodes the ALU operation.
module multicycle_control_fsm #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alucontrol,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       irwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        HALT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     cur;
    state_t     nxt;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;
    logic       irw;
    logic       memw;
    logic       regw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= FETCH;
        else       cur <= nxt;
    end

    always_comb begin
        nxt        = FETCH;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        aluop      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        irw        = 1'b0;
        memw       = 1'b0;
        iord       = 1'b0;
        regw       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        unique case (cur)
            FETCH: begin
                irw     = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
                nxt     = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:         nxt = EXECUTE;
                    OP_BEQ:       nxt = BRANCH;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JUMP;
                    default: begin
                        illegal = 1'b1;
                        nxt     = ILLEGAL_TRAP ? HALT : FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nxt     = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord = 1'b1;
                nxt  = MEMWB;
            end
            MEMWB: begin
                regw       = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memw       = 1'b1;
                instr_done = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                nxt     = ALUWB;
            end
            ALUWB: begin
                regw       = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nxt     = ADDIWB;
            end
            ADDIWB: begin
                regw       = 1'b1;
                instr_done = 1'b1;
            end
            JUMP: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
            end
            HALT: begin
                illegal = 1'b1;
                nxt     = HALT;
            end
            default: nxt = FETCH;
        endcase
    end

    always_comb begin
        alucontrol = 3'b011;
        case (aluop)
            2'b00: alucontrol = 3'b010;
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b011;
                endcase
            end
            default: alucontrol = 3'b011;
        endcase
    end

    // Reset must suppress every write even though state already reads FETCH
    assign pcen     = ~reset & (pcwrite | (branch & zero));
    assign irwrite  = ~reset & irw;
    assign memwrite = ~reset & memw;
    assign regwrite = ~reset & regw;
    assign state    = cur;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main controller for the 32-bit non-pipelined (multicycle) datapath, and the producer side of the ALU interface.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives all datapath enables and mux selects, and decodes the 3-bit ALU operation code.
- Consumes the ALU zero flag to resolve branches.

Parameters:
ILLEGAL_TRAP, 0, 0: an unknown opcode returns to FETCH; 1: an unknown opcode enters HALT until reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
op  input  6  opcode field from instruction register
funct  input  6  function field from instruction register
zero  input  1  ALU zero flag
alucontrol  output  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 no-op
alusrca  output  1  ALU A select: 0 PC, 1 register A
alusrcb  output  2  ALU B select: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2
pcsrc  output  2  PC source: 00 ALU result, 01 ALUOut register, 10 jump target
pcen  output  1  PC write enable
irwrite  output  1  instruction register write
memwrite  output  1  memory write
iord  output  1  memory address: 0 PC, 1 ALUOut
regwrite  output  1  register file write
regdst  output  1  destination: 0 rt, 1 rd
memtoreg  output  1  writeback data: 0 ALUOut, 1 memory data
instr_done  output  1  high in the final cycle of each instruction
illegal  output  1  unknown opcode indicator
state  output  4  current state (debug)

Behaviour:
- Moore FSM with a 4-bit state register. Outputs are combinational from state; pcen and alucontrol also depend on the inputs noted below.
- Reset: an asynchronous assert forces state=FETCH(0).
  - While reset=1, pcen, irwrite, memwrite and regwrite are forced to 0.
  - All other outputs take their FETCH values.
  - A reset asserted mid-instruction aborts it immediately, with no further writes.
- State encoding: FETCH0, DECODE1, MEMADR2, MEMRD3, MEMWB4, MEMWR5, EXECUTE6, ALUWB7, BRANCH8, ADDIEX9, ADDIWB10, JUMP11, HALT12. Codes 13-15 go to FETCH on the next edge.
- Transitions:
  - FETCH->DECODE.
  - DECODE, by op:
    - lw 100011 or sw 101011 -> MEMADR
    - R-type 000000 -> EXECUTE
    - beq 000100 -> BRANCH
    - addi 001000 -> ADDIEX
    - j 000010 -> JUMP
    - any other op -> FETCH if ILLEGAL_TRAP=0, else HALT
  - MEMADR -> MEMRD if lw, else MEMWR.
  - MEMRD->MEMWB.
  - EXECUTE->ALUWB.
  - ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
  - HALT -> HALT.
- Per-state outputs (anything unlisted is 0; aluop is internal):
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00
  - DECODE: alusrcb=11, aluop=00
  - MEMADR, ADDIEX: alusrca=1, alusrcb=10, aluop=00
  - MEMRD: iord=1
  - MEMWB: regwrite=1, memtoreg=1
  - MEMWR: iord=1, memwrite=1
  - EXECUTE: alusrca=1, aluop=10
  - ALUWB: regwrite=1, regdst=1
  - BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1
  - ADDIWB: regwrite=1
  - JUMP: pcsrc=10, pcwrite=1
  - HALT: illegal=1
- pcen = pcwrite | (branch & zero), evaluated in the same cycle.
- ALU decode:
  - aluop 00 -> 010; aluop 01 -> 110.
  - aluop 10 uses funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
  - Any other funct -> 011, so the ALU yields 0.
  - aluop 11 is unused and maps to 011.
- illegal: with ILLEGAL_TRAP=0, high only in DECODE when op is unknown; with ILLEGAL_TRAP=1, also held in HALT.
- instr_done: high in the terminal states MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP.
- Instruction latency in cycles, including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- op and funct are sampled continuously. They must be stable from DECODE until instr_done; the instruction register guarantees this.

Test Plan:
- Reset then lw (op=100011) -> state sequence 0,1,2,3,4,0.
  - irwrite=1 only in cycle 0; regwrite=1 and memtoreg=1 only in cycle 4.
  - instr_done=1 in cycle 4.
- R-type funct=101010 -> alucontrol=111 in EXECUTE, regdst=1 and regwrite=1 in ALUWB, 4 cycles.
  - funct=000000 gives alucontrol=011.
- beq with zero=1 in BRANCH -> pcen=1, pcsrc=01, alucontrol=110.
  - With zero=0, pcen=0; 3 cycles in both cases.
- sw, then j -> memwrite=1 and iord=1 only in MEMWR.
  - JUMP gives pcsrc=10, pcen=1.
  - Sequences 0,1,2,5 and 0,1,11.
- op=111111 with ILLEGAL_TRAP=0 -> illegal=1 in DECODE, then FETCH.
  - With ILLEGAL_TRAP=1 -> state stays 12, illegal=1, and all enables stay 0 until reset.
- Assert reset asynchronously mid-cycle in MEMWR -> state=0 and memwrite=0 immediately, before the next clk edge.
  - After release, a FETCH begins on the first edge.
